// File: rtl/riscv_hwloop_regs_tracker_pkg.sv
// Shared types and write-enable bit positions for the hardware-loop register tracker.
package riscv_hwloop_pkg;

    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    typedef logic [31:0] hwlp_addr_t;
    typedef logic [31:0] hwlp_cnt_t;

endpackage

// File: rtl/riscv_hwloop_regs_tracker_if.sv
// Bundle between the ID stage / hwloop controller and the loop register tracker.
interface riscv_hwloop_regs_tracker_if #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) ();
    import riscv_hwloop_pkg::*;

    hwlp_addr_t                  hwlp_start_data_i;
    hwlp_addr_t                  hwlp_end_data_i;
    hwlp_cnt_t                   hwlp_cnt_data_i;
    logic [2:0]                  hwlp_we_i;
    logic [N_REG_BITS-1:0]       hwlp_regid_i;
    logic                        valid_i;
    logic [N_REGS-1:0]           hwlp_dec_cnt_i;
    logic                        if_valid_i;
    logic                        id_valid_i;
    logic                        flush_i;
    hwlp_addr_t [N_REGS-1:0]     hwlp_start_addr_o;
    hwlp_addr_t [N_REGS-1:0]     hwlp_end_addr_o;
    hwlp_cnt_t  [N_REGS-1:0]     hwlp_counter_o;
    logic [N_REGS-1:0]           hwlp_dec_cnt_id_o;

    modport master (
        output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
               hwlp_regid_i, valid_i, hwlp_dec_cnt_i, if_valid_i, id_valid_i, flush_i,
        input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
    );

    modport slave (
        input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
               hwlp_regid_i, valid_i, hwlp_dec_cnt_i, if_valid_i, id_valid_i, flush_i,
        output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
    );

endinterface

// File: rtl/riscv_hwloop_regs_tracker_pending.sv
// One loop's "decrement pending" flop: set when the loop-end instruction enters ID,
// consumed when it retires, dropped on flush.
module riscv_hwloop_pending (
    input  logic clk,
    input  logic rst,
    input  logic if_valid_i,
    input  logic dec_cnt_i,
    input  logic id_valid_i,
    input  logic flush_i,
    output logic pending_o,
    output logic retire_o
);

    logic pending_q, pending_d;

    // A flushed instruction never consumes an iteration.
    assign retire_o  = pending_q & id_valid_i & ~flush_i;
    assign pending_o = pending_q;

    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = 1'b0;
        end else if (if_valid_i && dec_cnt_i) begin
            pending_d = 1'b1;
        end else if (id_valid_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/riscv_hwloop_regs_tracker.sv
// Per-loop start/end/counter storage feeding the hwloop controller; counter decrements
// are deferred until the loop-end instruction retires from ID.
module riscv_hwloop_regs_tracker
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    riscv_hwloop_regs_tracker_if.slave  hw
);

    hwlp_addr_t [N_REGS-1:0] start_addr_q, start_addr_d;
    hwlp_addr_t [N_REGS-1:0] end_addr_q,   end_addr_d;
    hwlp_cnt_t  [N_REGS-1:0] counter_q,    counter_d;
    logic       [N_REGS-1:0] pending;
    logic       [N_REGS-1:0] retire;
    logic       [N_REGS-1:0] wr_sel;

    function automatic hwlp_cnt_t sat_dec(input hwlp_cnt_t cnt);
        return (cnt == '0) ? cnt : cnt - 32'd1;
    endfunction

    for (genvar i = 0; i < N_REGS; i++) begin : g_pend
        riscv_hwloop_pending u_pending (
            .clk        (clk),
            .rst        (rst),
            .if_valid_i (hw.if_valid_i),
            .dec_cnt_i  (hw.hwlp_dec_cnt_i[i]),
            .id_valid_i (hw.id_valid_i),
            .flush_i    (hw.flush_i),
            .pending_o  (pending[i]),
            .retire_o   (retire[i])
        );
    end

    // Out-of-range loop indices match no entry, so such writes fall away.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < N_REGS; i++) begin
            wr_sel[i] = hw.valid_i && (hw.hwlp_regid_i == N_REG_BITS'(i));
        end
    end

    always_comb begin
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        counter_d    = counter_q;
        for (int i = 0; i < N_REGS; i++) begin
            if (retire[i]) begin
                counter_d[i] = sat_dec(counter_q[i]);
            end
            if (wr_sel[i] && hw.hwlp_we_i[HWLP_WE_START]) begin
                start_addr_d[i] = hw.hwlp_start_data_i;
            end
            if (wr_sel[i] && hw.hwlp_we_i[HWLP_WE_END]) begin
                end_addr_d[i] = hw.hwlp_end_data_i;
            end
            // A software write overrides a retiring decrement on the same loop.
            if (wr_sel[i] && hw.hwlp_we_i[HWLP_WE_CNT]) begin
                counter_d[i] = hw.hwlp_cnt_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_addr_q <= '0;
            end_addr_q   <= '0;
            counter_q    <= '0;
        end else begin
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            counter_q    <= counter_d;
        end
    end

    assign hw.hwlp_start_addr_o = start_addr_q;
    assign hw.hwlp_end_addr_o   = end_addr_q;
    assign hw.hwlp_counter_o    = counter_q;
    assign hw.hwlp_dec_cnt_id_o = pending;

endmodule

// File: tb/tb_riscv_hwloop_regs_tracker.sv
// Scoreboard bench for riscv_hwloop_regs_tracker: directed scenarios then random traffic
// against a rule-level loop model.
module tb_riscv_hwloop_regs_tracker;
    import riscv_hwloop_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic [N-1:0][31:0] st;
        logic [N-1:0][31:0] en;
        logic [N-1:0][31:0] cnt;
        logic [N-1:0]       pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_hwloop_regs_tracker_if #(.N_REGS(N)) hw ();

    riscv_hwloop_regs_tracker #(.N_REGS(N)) dut (
        .clk (clk),
        .rst (rst),
        .hw  (hw)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_st[N];
    logic [31:0] m_en[N];
    logic [31:0] m_cnt[N];
    bit          m_pend[N];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the loop state must be after the edge.
    task automatic step(input bit r, input bit v, input logic [2:0] we, input int rid,
                        input logic [31:0] sd, input logic [31:0] ed, input logic [31:0] cd,
                        input logic [1:0] dec, input bit ifv, input bit idv, input bit fl);
        exp_t e;
        @(negedge clk);
        rst                  = r;
        hw.valid_i           = v;
        hw.hwlp_we_i         = we;
        hw.hwlp_regid_i      = rid[0];
        hw.hwlp_start_data_i = sd;
        hw.hwlp_end_data_i   = ed;
        hw.hwlp_cnt_data_i   = cd;
        hw.hwlp_dec_cnt_i    = dec;
        hw.if_valid_i        = ifv;
        hw.id_valid_i        = idv;
        hw.flush_i           = fl;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_st[i] = 0; m_en[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
            end else begin
                bit wr;
                bit consumed;
                wr       = v && (rid == i);
                consumed = m_pend[i] && idv && !fl;
                if (consumed && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
                if (wr && we[2]) m_cnt[i] = cd;
                if (wr && we[0]) m_st[i] = sd;
                if (wr && we[1]) m_en[i] = ed;
                // Pending survives only if newly captured, or held through a stall.
                m_pend[i] = !fl && ((ifv && dec[i]) || (m_pend[i] && !idv));
            end
            e.st[i]   = m_st[i];
            e.en[i]   = m_en[i];
            e.cnt[i]  = m_cnt[i];
            e.pend[i] = m_pend[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit idv);
        step(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, idv, 0);
    endtask

    task automatic wr_cnt(input int rid, input logic [31:0] c);
        step(0, 1, 3'b100, rid, 0, 0, c, 2'b00, 0, 0, 0);
    endtask

    task automatic capture(input logic [1:0] dec);
        step(0, 0, 3'b000, 0, 0, 0, 0, dec, 1, 0, 0);
    endtask

    // Monitor: the outputs are registered every cycle, so each edge owes one record.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("start[%0d]", i), hw.hwlp_start_addr_o[i], e.st[i]);
                    check($sformatf("end[%0d]", i), hw.hwlp_end_addr_o[i], e.en[i]);
                    check($sformatf("counter[%0d]", i), hw.hwlp_counter_o[i], e.cnt[i]);
                    check($sformatf("pending[%0d]", i), {31'd0, hw.hwlp_dec_cnt_id_o[i]},
                          {31'd0, e.pend[i]});
                end
            end
        end
    end

    initial begin
        int budget;
        hw.valid_i = 0; hw.hwlp_we_i = 0; hw.hwlp_regid_i = 0;
        hw.hwlp_start_data_i = 0; hw.hwlp_end_data_i = 0; hw.hwlp_cnt_data_i = 0;
        hw.hwlp_dec_cnt_i = 0; hw.if_valid_i = 0; hw.id_valid_i = 0; hw.flush_i = 0;

        // Reset, then write all three fields of loop 0 at once.
        step(1, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        step(1, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        idle(0);
        step(0, 1, 3'b111, 0, 32'h100, 32'h120, 32'd3, 2'b00, 0, 0, 0);
        idle(0);

        // Normal iteration on loop 0.
        capture(2'b01);
        idle(1);
        idle(0);

        // Stall then flush on loop 1.
        wr_cnt(1, 32'd9);
        capture(2'b10);
        idle(0); idle(0); idle(0);
        step(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        idle(1);

        // Saturation at zero.
        wr_cnt(0, 32'd0);
        capture(2'b01);
        idle(1);
        idle(0);

        // Write beats a same-cycle retire.
        wr_cnt(0, 32'd2);
        capture(2'b01);
        step(0, 1, 3'b100, 0, 0, 0, 32'd7, 2'b00, 0, 1, 0);
        idle(0);

        // Back-to-back loop ends.
        wr_cnt(0, 32'd5);
        capture(2'b01);
        step(0, 0, 3'b000, 0, 0, 0, 0, 2'b01, 1, 1, 0);
        idle(1);
        idle(0);

        // Reset in the middle of activity.
        capture(2'b11);
        step(1, 1, 3'b111, 1, 32'hdead, 32'hbeef, 32'd4, 2'b11, 1, 1, 0);
        idle(0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [1:0] dec;
            logic [31:0] cd;
            dec = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'(1 << $urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) dec = 2'b00;
            cd  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom, $urandom, cd,
                 dec, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0);
        end
        idle(0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
